spi_xfer_sequencer: RTL and testbench
=====================================

SPI_XFER_SEQUENCER -- requirements
Module: spi_xfer_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning TX and RX FIFO depth in bytes (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles to wait for any core_ready edge (1..255).
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cfg_start  input  1  one-cycle pulse; starts the configuration phase.
REQ-006 cfg_word  input  7  {mode, len, cpol, cpha, div[2:0]}; sampled on cfg_start.
REQ-007 tx_valid / tx_ready / tx_data[7:0]  input/output/input  host push port into the TX FIFO.
REQ-008 rx_valid / rx_ready / rx_data[7:0]  output/input/output  host pop port from the RX FIFO.
REQ-009 bus_out[7:0], bus_oe  output  byte driven toward the SPI core data bus, and its drive enable.
REQ-010 bus_in[7:0]  input  value on the core data bus (core drives the received byte).
REQ-011 core_ready  input  1  core ready/set flag.
REQ-012 core_received  output  1  one-cycle acknowledge to the core after a received byte is captured.
REQ-013 configured, busy, err  output  1 each  configuration done / sequencer not idle / sticky timeout flag.

Function
REQ-014 TX and RX FIFOs SHALL transfer on valid&&ready; tx_ready=!tx_full; rx_valid=!rx_empty; rx_data SHALL be the head byte, combinational from storage.
REQ-015 Simultaneous push and pop on one FIFO SHALL both succeed; the count SHALL stay unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-016 States: IDLE, CFG, XLOAD, XACK, XRUN, XCAP, XREL.
REQ-017 IDLE: cfg_start SHALL go to CFG. Otherwise, if configured, TX FIFO not empty and RX FIFO not full, SHALL pop TX head into a hold register and go to XLOAD. cfg_start SHALL take priority.
REQ-018 CFG: bus_oe=1 and bus_out={cfg_word,1'b0}. On core_ready=1 SHALL set configured=1 and return to IDLE. The word SHALL be held at least 2 cycles before leaving.
REQ-019 XLOAD: bus_oe=1, bus_out=hold byte. SHALL go to XACK the next cycle.
REQ-020 XACK: bus kept driven. core_ready=1 (byte accepted) SHALL go to XRUN and drop bus_oe in that same transition.
REQ-021 XRUN: bus_oe=0. The sequencer SHALL wait for core_ready to fall, then rise again (transfer complete), then go to XCAP.
REQ-022 XCAP: SHALL push bus_in into the RX FIFO, assert core_received for exactly 1 cycle, and go to XREL.
REQ-023 XREL: SHALL wait for core_ready=0, then go to IDLE.
REQ-024 Each wait in CFG/XACK/XRUN/XREL SHALL use an 8-bit cycle counter cleared on state entry. Reaching TIMEOUT SHALL set err, drop the current byte with no RX push, drive bus_oe=0, and return to IDLE.
REQ-025 A TX byte equal to the previous TX byte goes undetected by the core. It SHALL therefore time out in XACK and set err. This is the defined behaviour, not a fault of this block.
REQ-026 cfg_start outside IDLE SHALL be ignored. Once err is set, it SHALL clear only on cfg_start or rst.
REQ-027 busy SHALL equal (state!=IDLE). Latency from TX pop to RX push SHALL be 3 cycles plus the core transfer time.

Reset
REQ-028 On rst: state=IDLE, both FIFOs empty, configured=0, err=0, bus_oe=0, bus_out=0, core_received=0, counter=0.
REQ-029 rst mid-transfer SHALL discard the held byte and all FIFO contents immediately (asynchronous).

Verification
REQ-030 cfg_word=7'b1000110, cfg_start pulse, core model raises core_ready after 3 cycles -> bus_out=8'h8C for at least 2 cycles, configured=1, bus_oe=0 after return to IDLE.
REQ-031 Push 8'hA5 -> bus_out=8'hA5 with bus_oe=1. Core model acks, drops ready, then raises ready with bus_in=8'h3C -> RX head=8'h3C, core_received high exactly 1 cycle.
REQ-032 Push 4 bytes back-to-back with FIFO_DEPTH=4 -> tx_ready=0 after the 4th push. All 4 transferred in order. RX order matches.
REQ-033 RX FIFO full with rx_ready=0 -> no TX pop; busy=0. Pop one RX entry -> the next transfer starts.
REQ-034 Core never raises ready in XACK -> err=1 after TIMEOUT cycles, byte dropped, state IDLE, bus_oe=0.
REQ-035 rst asserted while in XRUN -> all outputs at reset values in the same cycle, FIFOs empty, configured=0.

Source files
------------

// File: rtl/spi_xfer_sequencer.sv
// SPI transfer sequencer: buffers host bytes in a TX FIFO, walks each byte
// through the SPI core handshake on a shared data bus, and collects the
// received bytes in an RX FIFO. Every core wait is bounded by a cycle counter.
module spi_xfer_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_start,
    input  logic [6:0] cfg_word,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    input  logic [7:0] bus_in,
    input  logic       core_ready,
    output logic       core_received,
    output logic       configured,
    output logic       busy,
    output logic       err
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]    CYC_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, CFG, XLOAD, XACK, XRUN, XCAP, XREL} state_t;

    state_t        state;
    logic [7:0]    cyc;
    logic          seen_low;

    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic [AW:0]   tx_cnt, rx_cnt;

    logic tx_push, tx_pop, rx_push, rx_pop;
    logic tx_empty, rx_full;
    logic wait_state, wait_done, wait_expired;

    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == CNT_FULL);
    assign tx_ready = (tx_cnt != CNT_FULL);
    assign rx_valid = (rx_cnt != '0);
    assign rx_data  = rx_mem[rx_rd];
    assign busy     = (state != IDLE);

    assign tx_push = tx_valid && tx_ready;
    assign rx_pop  = rx_valid && rx_ready;
    // A byte is only launched when its reply is guaranteed a slot in the RX FIFO.
    assign tx_pop  = (state == IDLE) && !cfg_start && configured && !tx_empty && !rx_full;
    assign rx_push = (state == XCAP);

    // Exit condition of whichever core wait is active; a timeout fires only if it is not met.
    always_comb begin
        wait_state = 1'b0;
        wait_done  = 1'b0;
        case (state)
            CFG:  begin wait_state = 1'b1; wait_done = core_ready && (cyc != 8'd0); end
            XACK: begin wait_state = 1'b1; wait_done = core_ready; end
            XRUN: begin wait_state = 1'b1; wait_done = seen_low && core_ready; end
            XREL: begin wait_state = 1'b1; wait_done = !core_ready; end
            default: ;
        endcase
        wait_expired = wait_state && !wait_done && (cyc == CYC_LAST);
    end

    // FIFO storage carries no reset; emptiness is defined by the counters alone.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr] <= tx_data;
        if (rx_push) rx_mem[rx_wr] <= bus_in;
    end

    // FIFO pointers and occupancy; push and pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr <= '0; tx_rd <= '0; tx_cnt <= '0;
            rx_wr <= '0; rx_rd <= '0; rx_cnt <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + PTR_ONE;
            if (tx_pop)  tx_rd <= tx_rd + PTR_ONE;
            if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + CNT_ONE;
            else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - CNT_ONE;
            if (rx_push) rx_wr <= rx_wr + PTR_ONE;
            if (rx_pop)  rx_rd <= rx_rd + PTR_ONE;
            if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + CNT_ONE;
            else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - CNT_ONE;
        end
    end

    // Sequencer FSM; bus_out doubles as the hold register for the byte in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cyc           <= 8'd0;
            seen_low      <= 1'b0;
            configured    <= 1'b0;
            err           <= 1'b0;
            bus_oe        <= 1'b0;
            bus_out       <= 8'd0;
            core_received <= 1'b0;
        end else begin
            core_received <= 1'b0;
            if (wait_expired) begin
                err     <= 1'b1;
                bus_oe  <= 1'b0;
                bus_out <= 8'd0;
                cyc     <= 8'd0;
                state   <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        cyc <= 8'd0;
                        if (cfg_start) begin
                            err     <= 1'b0;
                            bus_oe  <= 1'b1;
                            bus_out <= {cfg_word, 1'b0};
                            state   <= CFG;
                        end else if (tx_pop) begin
                            bus_oe  <= 1'b1;
                            bus_out <= tx_mem[tx_rd];
                            state   <= XLOAD;
                        end
                    end
                    CFG: begin
                        if (wait_done) begin
                            configured <= 1'b1;
                            bus_oe     <= 1'b0;
                            bus_out    <= 8'd0;
                            cyc        <= 8'd0;
                            state      <= IDLE;
                        end else begin
                            cyc <= cyc + 8'd1;
                        end
                    end
                    XLOAD: begin
                        cyc   <= 8'd0;
                        state <= XACK;
                    end
                    XACK: begin
                        if (wait_done) begin
                            bus_oe   <= 1'b0;
                            seen_low <= 1'b0;
                            cyc      <= 8'd0;
                            state    <= XRUN;
                        end else begin
                            cyc <= cyc + 8'd1;
                        end
                    end
                    XRUN: begin
                        if (wait_done) begin
                            core_received <= 1'b1;
                            cyc           <= 8'd0;
                            state         <= XCAP;
                        end else begin
                            cyc <= cyc + 8'd1;
                            if (!core_ready) seen_low <= 1'b1;
                        end
                    end
                    XCAP: begin
                        cyc   <= 8'd0;
                        state <= XREL;
                    end
                    XREL: begin
                        if (wait_done) begin
                            cyc   <= 8'd0;
                            state <= IDLE;
                        end else begin
                            cyc <= cyc + 8'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer with a scripted core model and
// TX/RX scoreboards.
module tb_spi_xfer_sequencer;
    localparam int DEPTH = 4;
    localparam int TMO   = 40;
    localparam int LIM   = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_start = 1'b0;
    logic [6:0] cfg_word = 7'd0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] tx_data = 8'd0;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [7:0] bus_in = 8'd0;
    logic       core_ready = 1'b0;
    logic       core_received;
    logic       configured;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;
    logic [7:0] txq[$];
    logic [7:0] rxq[$];

    spi_xfer_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_word(cfg_word),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
        .core_ready(core_ready), .core_received(core_received),
        .configured(configured), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] d);
        int n = 0;
        while (!tx_ready && n < LIM) begin @(negedge clk); n++; end
        chk("push_wait", n < LIM, 1);
        tx_valid = 1'b1;
        tx_data  = d;
        txq.push_back(d);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic pop_rx(input string tag);
        int n = 0;
        while (!rx_valid && n < LIM) begin @(negedge clk); n++; end
        chk("pop_wait", n < LIM, 1);
        chk(tag, rx_data, rxq.pop_front());
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic do_config(input logic [6:0] w, input logic [7:0] exp_bus);
        int hold = 0;
        int n = 0;
        cfg_word  = w;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("cfg_bus", bus_out, exp_bus);
        chk("cfg_oe", bus_oe, 1);
        chk("cfg_err_clr", err, 0);
        for (int k = 0; k < 3; k++) begin
            if (bus_oe && bus_out == exp_bus) hold++;
            @(negedge clk);
        end
        core_ready = 1'b1;
        while (busy && n < LIM) begin
            if (bus_oe && bus_out == exp_bus) hold++;
            @(negedge clk);
            n++;
        end
        chk("cfg_done_wait", n < LIM, 1);
        core_ready = 1'b0;
        chk("cfg_hold", hold >= 2, 1);
        chk("configured", configured, 1);
        chk("cfg_oe_off", bus_oe, 0);
    endtask

    // Full core handshake for the next queued TX byte, replying with 'reply'.
    task automatic core_xfer(input logic [7:0] reply);
        int n = 0;
        logic [7:0] exp_tx;
        exp_tx = txq.pop_front();
        while (!(busy && bus_oe) && n < LIM) begin @(negedge clk); n++; end
        chk("xfer_start_wait", n < LIM, 1);
        chk("tx_on_bus", bus_out, exp_tx);
        core_ready = 1'b1;
        n = 0;
        while (bus_oe && n < LIM) begin @(negedge clk); n++; end
        chk("ack_wait", n < LIM, 1);
        core_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus_in = reply;
        rxq.push_back(reply);
        core_ready = 1'b1;
        n = 0;
        while (!core_received && n < LIM) begin @(negedge clk); n++; end
        chk("rcv_wait", n < LIM, 1);
        @(negedge clk);
        chk("rcv_one_cycle", core_received, 0);
        core_ready = 1'b0;
        n = 0;
        while (busy && n < LIM) begin @(negedge clk); n++; end
        chk("rel_wait", n < LIM, 1);
    endtask

    initial begin
        int n;
        logic [7:0] dropped;

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_cfgd", configured, 0);
        chk("rst_err", err, 0);
        chk("rst_oe", bus_oe, 0);
        chk("rst_bus", bus_out, 8'h00);
        chk("rst_rcv", core_received, 0);
        chk("rst_txrdy", tx_ready, 1);
        chk("rst_rxvld", rx_valid, 0);
        rst = 1'b0;
        @(negedge clk);

        // configuration
        do_config(7'b1000110, 8'h8C);

        // single transfer
        push_tx(8'hA5);
        core_xfer(8'h3C);
        pop_rx("rx_head_3c");

        // fill the RX FIFO without draining it
        for (int i = 0; i < 4; i++) begin
            push_tx(8'(i + 1));
            core_xfer(8'(17 * (i + 1)));
        end
        chk("rx_full_vld", rx_valid, 1);
        chk("rx_full_idle", busy, 0);

        // RX full: four back-to-back pushes fill TX, nothing launches
        for (int i = 0; i < 4; i++) push_tx(8'(192 + i));
        chk("tx_full", tx_ready, 0);
        repeat (5) @(negedge clk);
        chk("stall_busy", busy, 0);
        chk("stall_no_pop", tx_ready, 0);
        pop_rx("rx_a0");
        n = 0;
        while (!busy && n < LIM) begin @(negedge clk); n++; end
        chk("resume_wait", n < LIM, 1);
        chk("resume_txrdy", tx_ready, 1);
        core_xfer(8'h55);
        for (int i = 0; i < 4; i++) pop_rx("rx_order1");
        for (int i = 0; i < 3; i++) core_xfer(8'(102 + 17 * i));
        for (int i = 0; i < 3; i++) pop_rx("rx_order2");
        chk("drained_vld", rx_valid, 0);
        chk("drained_busy", busy, 0);

        // core never acknowledges: timeout
        push_tx(8'hE7);
        dropped = txq.pop_back();
        n = 0;
        while (!bus_oe && n < LIM) begin @(negedge clk); n++; end
        chk("tmo_start_wait", n < LIM, 1);
        chk("tmo_bus", bus_out, dropped);
        n = 0;
        while (bus_oe && n < LIM) begin n++; @(negedge clk); end
        chk("tmo_len", n, TMO + 1);
        chk("tmo_err", err, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_oe", bus_oe, 0);
        chk("tmo_no_rx", rx_valid, 0);
        repeat (3) @(negedge clk);
        chk("err_sticky", err, 1);
        do_config(7'b0101011, 8'h56);
        chk("err_cleared", err, 0);

        // asynchronous reset while in XRUN
        push_tx(8'h5A);
        core_xfer(8'h99);
        chk("pre_rst_rx", rx_valid, 1);
        push_tx(8'h6B);
        push_tx(8'h7C);
        n = 0;
        while (!(busy && bus_oe) && n < LIM) begin @(negedge clk); n++; end
        chk("xrun_start_wait", n < LIM, 1);
        chk("xrun_bus", bus_out, 8'h6B);
        core_ready = 1'b1;
        n = 0;
        while (bus_oe && n < LIM) begin @(negedge clk); n++; end
        chk("xrun_ack_wait", n < LIM, 1);
        core_ready = 1'b0;
        @(negedge clk);
        chk("xrun_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_oe", bus_oe, 0);
        chk("arst_bus", bus_out, 8'h00);
        chk("arst_cfgd", configured, 0);
        chk("arst_err", err, 0);
        chk("arst_rcv", core_received, 0);
        chk("arst_rxvld", rx_valid, 0);
        chk("arst_txrdy", tx_ready, 1);
        txq.delete();
        rxq.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_config(7'b1000110, 8'h8C);
        repeat (8) @(negedge clk);
        chk("post_rst_tx_empty", busy, 0);
        chk("post_rst_rx_empty", rx_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
